// File: rtl/corevx_mem_arbiter.sv
// Two-master to one-slave Avalon-style memory arbiter (port 0 = dcache, port 1 = icache).
// Grants the bus per burst and steers read beats back to the owning master only.
module corevx_mem_arbiter #(
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned BURST_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*34-1:0]      r_address,
    input  logic [2*BURST_W-1:0] r_burstcount,
    input  logic [1:0]           r_read,
    input  logic [1:0]           r_write,
    input  logic [2*32-1:0]      r_writedata,
    input  logic [2*4-1:0]       r_byteenable,
    output logic [1:0]           r_waitrequest,
    output logic [31:0]          r_readdata,
    output logic [1:0]           r_readdatavalid,
    output logic [1:0]           r_response,
    output logic [33:0]          m_address,
    output logic [BURST_W-1:0]   m_burstcount,
    output logic                 m_read,
    output logic                 m_write,
    output logic [31:0]          m_writedata,
    output logic [3:0]           m_byteenable,
    input  logic                 m_waitrequest,
    input  logic [31:0]          m_readdata,
    input  logic                 m_readdatavalid,
    input  logic [1:0]           m_response
);

    typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

    localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

    state_t             state;
    logic               owner;
    logic               last_grant;
    logic [BURST_W-1:0] beats_left;

    logic [1:0]         req;
    logic               sel;
    logic               fwd;
    logic               in_idle;
    logic [BURST_W-1:0] bc_eff;

    assign req     = r_read | r_write;
    assign in_idle = (state == IDLE);

    // During a write burst the owner keeps the mux even if it drops r_write.
    always_comb begin
        sel = 1'b0;
        if (state == WBURST) begin
            sel = owner;
        end else if (req == 2'b10) begin
            sel = 1'b1;
        end else if (req == 2'b11 && ROUND_ROBIN != 0) begin
            sel = ~last_grant;
        end
    end

    assign fwd = rst_n && ((in_idle && (req != 2'b00)) || (state == WBURST));

    always_comb begin
        m_address    = sel ? r_address[67:34] : r_address[33:0];
        m_burstcount = sel ? r_burstcount[2*BURST_W-1:BURST_W] : r_burstcount[BURST_W-1:0];
        m_writedata  = sel ? r_writedata[63:32] : r_writedata[31:0];
        m_byteenable = sel ? r_byteenable[7:4] : r_byteenable[3:0];
        m_read       = fwd && in_idle && r_read[sel];
        // A read and write from the same master in IDLE: the read wins.
        m_write      = fwd && r_write[sel] && !(in_idle && r_read[sel]);
    end

    always_comb begin
        r_waitrequest = 2'b11;
        if (fwd) begin
            r_waitrequest[sel] = m_waitrequest;
        end
    end

    always_comb begin
        r_readdatavalid = 2'b00;
        if (rst_n && state == RBURST && m_readdatavalid) begin
            r_readdatavalid[owner] = 1'b1;
        end
    end

    assign r_readdata = m_readdata;
    assign r_response = m_response;

    assign bc_eff = (m_burstcount == '0) ? ONE : m_burstcount;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            beats_left <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m_read && !m_waitrequest) begin
                        owner      <= sel;
                        beats_left <= bc_eff;
                        state      <= RBURST;
                    end else if (m_write && !m_waitrequest) begin
                        if (bc_eff == ONE) begin
                            last_grant <= sel;
                        end else begin
                            owner      <= sel;
                            beats_left <= bc_eff - ONE;
                            state      <= WBURST;
                        end
                    end
                end
                RBURST: begin
                    // Error beats still count; the burst always runs to completion.
                    if (m_readdatavalid) begin
                        beats_left <= beats_left - ONE;
                        if (beats_left == ONE) begin
                            state      <= IDLE;
                            last_grant <= owner;
                        end
                    end
                end
                WBURST: begin
                    if (m_write && !m_waitrequest) begin
                        beats_left <= beats_left - ONE;
                        if (beats_left == ONE) begin
                            state      <= IDLE;
                            last_grant <= owner;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corevx_mem_arbiter.sv
// Scoreboard bench for corevx_mem_arbiter: directed master traffic against a simple
// memory model, with a monitor checking every accept and read beat against queued expectations.
module tb_corevx_mem_arbiter;

    localparam int BW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [67:0]    r_address;
    logic [2*BW-1:0] r_burstcount;
    logic [1:0]     r_read, r_write;
    logic [63:0]    r_writedata;
    logic [7:0]     r_byteenable;
    logic [1:0]     r_waitrequest, r_readdatavalid, r_response;
    logic [31:0]    r_readdata;
    logic [33:0]    m_address;
    logic [BW-1:0]  m_burstcount;
    logic           m_read, m_write;
    logic [31:0]    m_writedata;
    logic [3:0]     m_byteenable;
    logic           m_waitrequest;
    logic [31:0]    m_readdata;
    logic           m_readdatavalid;
    logic [1:0]     m_response;

    // Fixed-priority instance shares the master address/data inputs.
    logic [1:0]     fp_r_read, fp_r_write;
    logic [1:0]     fp_r_waitrequest, fp_r_readdatavalid, fp_r_response;
    logic [31:0]    fp_r_readdata;
    logic [33:0]    fp_m_address;
    logic [BW-1:0]  fp_m_burstcount;
    logic           fp_m_read, fp_m_write;
    logic [31:0]    fp_m_writedata;
    logic [3:0]     fp_m_byteenable;
    logic           fp_rdv = 1'b0;

    corevx_mem_arbiter #(.ROUND_ROBIN(1), .BURST_W(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r_address(r_address), .r_burstcount(r_burstcount), .r_read(r_read),
        .r_write(r_write), .r_writedata(r_writedata), .r_byteenable(r_byteenable),
        .r_waitrequest(r_waitrequest), .r_readdata(r_readdata),
        .r_readdatavalid(r_readdatavalid), .r_response(r_response),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
        .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .m_response(m_response)
    );

    corevx_mem_arbiter #(.ROUND_ROBIN(0), .BURST_W(BW)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .r_address(r_address), .r_burstcount(r_burstcount), .r_read(fp_r_read),
        .r_write(fp_r_write), .r_writedata(r_writedata), .r_byteenable(r_byteenable),
        .r_waitrequest(fp_r_waitrequest), .r_readdata(fp_r_readdata),
        .r_readdatavalid(fp_r_readdatavalid), .r_response(fp_r_response),
        .m_address(fp_m_address), .m_burstcount(fp_m_burstcount), .m_read(fp_m_read),
        .m_write(fp_m_write), .m_writedata(fp_m_writedata), .m_byteenable(fp_m_byteenable),
        .m_waitrequest(1'b0), .m_readdata(32'h0),
        .m_readdatavalid(fp_rdv), .m_response(2'b00)
    );

    function automatic logic [31:0] mem_data(input logic [33:0] a, input int b);
        return 32'hBEAFDEAD ^ a[31:0] ^ (32'(b) << 20);
    endfunction

    function automatic logic [1:0] mem_resp(input logic [33:0] a, input int b);
        return (a == 34'h200 && b == 1) ? 2'b11 : 2'b00;
    endfunction

    // Memory model: first read beat one cycle after accept, one beat per cycle; not reset.
    logic        mem_wait  = 1'b0;
    logic        rd_active = 1'b0;
    logic [33:0] rd_addr   = '0;
    int          rd_beat   = 0;
    int          rd_total  = 0;

    assign m_waitrequest   = mem_wait;
    assign m_readdatavalid = rd_active;
    assign m_readdata      = mem_data(rd_addr, rd_beat);
    assign m_response      = mem_resp(rd_addr, rd_beat);

    always @(posedge clk) begin
        if (rd_active) begin
            rd_beat <= rd_beat + 1;
            if (rd_beat == rd_total - 1) rd_active <= 1'b0;
        end
        if (m_read && !m_waitrequest) begin
            rd_active <= 1'b1;
            rd_addr   <= m_address;
            rd_beat   <= 0;
            rd_total  <= (m_burstcount == '0) ? 1 : int'(m_burstcount);
        end
    end

    always @(posedge clk) fp_rdv <= fp_m_read;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    typedef struct {
        logic        wr;
        logic [33:0] addr;
        logic [31:0] data;
        logic        after_last;
    } acc_exp_t;

    rd_exp_t  rd_q[$];
    acc_exp_t acc_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_beat_cyc = -10;
    logic p1_watch = 1'b0;
    logic fp_watch = 1'b0;
    int fp_grants = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        rd_exp_t  e;
        acc_exp_t a;
        #2;
        if (r_readdatavalid != 2'b00) begin
            if (rd_q.size() == 0) begin
                check("unexpected_rdv", 64'(r_readdatavalid), 64'h0);
            end else begin
                e = rd_q.pop_front();
                check("rd_valid", 64'(r_readdatavalid), e.port ? 64'h2 : 64'h1);
                check("rd_data", 64'(r_readdata), 64'(e.data));
                check("rd_resp", 64'(r_response), 64'(e.resp));
            end
            last_beat_cyc = cyc;
        end
        if ((m_read || m_write) && !m_waitrequest) begin
            if (acc_q.size() == 0) begin
                check("unexpected_accept", 64'({m_read, m_write}), 64'h0);
            end else begin
                a = acc_q.pop_front();
                check("acc_kind", 64'(m_write), 64'(a.wr));
                check("acc_addr", 64'(m_address), 64'(a.addr));
                if (a.wr) check("acc_wdata", 64'(m_writedata), 64'(a.data));
                if (a.after_last) check("acc_gap", 64'(cyc - last_beat_cyc), 64'h1);
            end
        end
        if (p1_watch) check("p1_waitreq", 64'(r_waitrequest[1]), 64'h1);
        if (fp_watch) begin
            check("fp_p1_waitreq", 64'(fp_r_waitrequest[1]), 64'h1);
            if (fp_m_read || fp_m_write) begin
                fp_grants++;
                check("fp_grant_addr", 64'(fp_m_address), 64'h7000);
            end
            if (fp_r_readdatavalid != 2'b00) check("fp_rdv", 64'(fp_r_readdatavalid), 64'h1);
        end
    end

    task automatic wait_accept(input int p);
        for (int n = 0; n < 300; n++) begin
            #1;
            if (!r_waitrequest[p]) begin
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: port %0d still stalled, required an accept", p);
    endtask

    task automatic master_read(input int p, input logic [33:0] a, input int bc);
        @(negedge clk);
        r_address[p*34 +: 34] = a;
        r_burstcount[p*BW +: BW] = BW'(bc);
        r_read[p] = 1'b1;
        wait_accept(p);
        @(negedge clk);
        r_read[p] = 1'b0;
    endtask

    task automatic master_write(input int p, input logic [33:0] a, input int bc,
                                input logic [31:0] d0);
        for (int i = 0; i < bc; i++) begin
            @(negedge clk);
            r_address[p*34 +: 34] = a;
            r_burstcount[p*BW +: BW] = BW'(bc);
            r_writedata[p*32 +: 32] = d0 + 32'(i);
            r_byteenable[p*4 +: 4] = 4'hF;
            r_write[p] = 1'b1;
            wait_accept(p);
        end
        @(negedge clk);
        r_write[p] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        r_address = '0; r_burstcount = '0; r_read = 2'b11; r_write = 2'b00;
        r_writedata = '0; r_byteenable = '0; fp_r_read = 2'b00; fp_r_write = 2'b00;
        repeat (2) @(negedge clk);
        #2;
        check("rst_m_read", 64'(m_read), 64'h0);
        check("rst_m_write", 64'(m_write), 64'h0);
        check("rst_waitreq", 64'(r_waitrequest), 64'h3);
        check("rst_rdv", 64'(r_readdatavalid), 64'h0);
        r_read = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("idle_waitreq", 64'(r_waitrequest), 64'h3);
        check("idle_m_read", 64'(m_read), 64'h0);

        // Single-beat read from port 0.
        p1_watch = 1'b1;
        rd_q.push_back(rd_exp_t'{1'b0, 32'hBEAFDEAD, 2'b00});
        acc_q.push_back(acc_exp_t'{1'b0, 34'h0, 32'h0, 1'b0});
        master_read(0, 34'h0, 1);
        repeat (3) @(negedge clk);
        p1_watch = 1'b0;

        // Contended 16-beat reads, then a contended 2-beat pair.
        do_reset();
        for (int i = 0; i < 16; i++) rd_q.push_back(rd_exp_t'{1'b0, mem_data(34'h1000, i), 2'b00});
        for (int i = 0; i < 16; i++) rd_q.push_back(rd_exp_t'{1'b1, mem_data(34'h2000, i), 2'b00});
        for (int i = 0; i < 2; i++) rd_q.push_back(rd_exp_t'{1'b0, mem_data(34'h1100, i), 2'b00});
        for (int i = 0; i < 2; i++) rd_q.push_back(rd_exp_t'{1'b1, mem_data(34'h2100, i), 2'b00});
        acc_q.push_back(acc_exp_t'{1'b0, 34'h1000, 32'h0, 1'b0});
        acc_q.push_back(acc_exp_t'{1'b0, 34'h2000, 32'h0, 1'b1});
        acc_q.push_back(acc_exp_t'{1'b0, 34'h1100, 32'h0, 1'b1});
        acc_q.push_back(acc_exp_t'{1'b0, 34'h2100, 32'h0, 1'b1});
        fork
            master_read(0, 34'h1000, 16);
            master_read(1, 34'h2000, 16);
        join
        fork
            master_read(0, 34'h1100, 2);
            master_read(1, 34'h2100, 2);
        join
        repeat (5) @(negedge clk);

        // Port 1 4-beat write with a stall; port 0 read posted mid-burst.
        for (int i = 0; i < 4; i++)
            acc_q.push_back(acc_exp_t'{1'b1, 34'h100, 32'hA000_0000 + 32'(i), 1'b0});
        acc_q.push_back(acc_exp_t'{1'b0, 34'h400, 32'h0, 1'b0});
        rd_q.push_back(rd_exp_t'{1'b0, mem_data(34'h400, 0), 2'b00});
        fork
            master_write(1, 34'h100, 4, 32'hA000_0000);
            begin repeat (2) @(negedge clk); master_read(0, 34'h400, 1); end
            begin repeat (2) @(negedge clk); mem_wait = 1'b1; repeat (2) @(negedge clk); mem_wait = 1'b0; end
        join
        repeat (3) @(negedge clk);

        // 4-beat read with an error on beat 2; port 1 waits for the whole burst.
        rd_q.push_back(rd_exp_t'{1'b0, mem_data(34'h200, 0), 2'b00});
        rd_q.push_back(rd_exp_t'{1'b0, mem_data(34'h200, 1), 2'b11});
        rd_q.push_back(rd_exp_t'{1'b0, mem_data(34'h200, 2), 2'b00});
        rd_q.push_back(rd_exp_t'{1'b0, mem_data(34'h200, 3), 2'b00});
        rd_q.push_back(rd_exp_t'{1'b1, mem_data(34'h300, 0), 2'b00});
        acc_q.push_back(acc_exp_t'{1'b0, 34'h200, 32'h0, 1'b0});
        acc_q.push_back(acc_exp_t'{1'b0, 34'h300, 32'h0, 1'b1});
        fork
            master_read(0, 34'h200, 4);
            begin repeat (2) @(negedge clk); master_read(1, 34'h300, 1); end
        join
        repeat (4) @(negedge clk);

        // Reset during beat 3 of an 8-beat read; later beats must be dropped.
        rd_q.push_back(rd_exp_t'{1'b0, mem_data(34'h500, 0), 2'b00});
        rd_q.push_back(rd_exp_t'{1'b0, mem_data(34'h500, 1), 2'b00});
        acc_q.push_back(acc_exp_t'{1'b0, 34'h500, 32'h0, 1'b0});
        master_read(0, 34'h500, 8);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midrst_rdv", 64'(r_readdatavalid), 64'h0);
        check("midrst_m_read", 64'(m_read), 64'h0);
        check("midrst_waitreq", 64'(r_waitrequest), 64'h3);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("postrst_rdv", 64'(r_readdatavalid), 64'h0);
        check("postrst_m_read", 64'(m_read), 64'h0);
        acc_q.push_back(acc_exp_t'{1'b1, 34'h600, 32'hC0FFEE00, 1'b0});
        @(negedge clk);
        r_address[67:34] = 34'h600;
        r_burstcount[2*BW-1:BW] = BW'(1);
        r_writedata[63:32] = 32'hC0FFEE00;
        r_write[1] = 1'b1;
        #2;
        check("postrst_idle_wr", 64'(m_write), 64'h1);
        check("postrst_waitreq", 64'(r_waitrequest), 64'h1);
        check("postrst_drop", 64'(r_readdatavalid), 64'h0);
        @(negedge clk);
        r_write[1] = 1'b0;
        repeat (8) @(negedge clk);

        // Fixed priority: continuous writes then reads from both ports.
        r_address = {34'h8000, 34'h7000};
        r_burstcount = {BW'(1), BW'(1)};
        fp_watch = 1'b1;
        fp_r_write = 2'b11;
        repeat (6) @(negedge clk);
        fp_r_write = 2'b00;
        fp_r_read = 2'b11;
        repeat (12) @(negedge clk);
        fp_r_read = 2'b00;
        fp_watch = 1'b0;
        @(negedge clk);
        check("fp_grants_seen", 64'(fp_grants >= 8), 64'h1);

        check("rd_q_drained", 64'(rd_q.size()), 64'h0);
        check("acc_q_drained", 64'(acc_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/corevx_mem_arbiter.md
Name: corevx_mem_arbiter

Overview:
Two-master to one-slave arbiter for the core's Avalon-style backing memory bus (34-bit address, burstcount, waitrequest, readdatavalid, 2-bit response). Port 0 is the data cache and port 1 is the instruction cache. The arbiter grants the bus to one master and holds the grant for a whole burst. Read responses are routed only to the owning master. The slave side connects directly to the memory/interconnect master port that corevx_cache drives today.

Parameters:
ROUND_ROBIN, 1, 1 = alternate priority after each completed burst; 0 = fixed priority, port 0 wins.
BURST_W, 5, burstcount width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
r_address  in  2x34  master address, packed {p1,p0}
r_burstcount  in  2xBURST_W  burst length per master
r_read  in  2  read request per master
r_write  in  2  write request per master
r_writedata  in  2x32  write data
r_byteenable  in  2x4  byte enables
r_waitrequest  out  2  per-master stall
r_readdata  out  32  shared readdata bus (qualify with r_readdatavalid)
r_readdatavalid  out  2  per-master beat valid
r_response  out  2  response of the current beat (00 OK, 11 error)
m_address  out  34  to memory
m_burstcount  out  BURST_W  to memory
m_read, m_write  out  1 each  to memory
m_writedata  out  32  to memory
m_byteenable  out  4  to memory
m_waitrequest  in  1  from memory
m_readdata  in  32  from memory
m_readdatavalid  in  1  from memory
m_response  in  2  from memory

Behaviour:
- State register: IDLE, RBURST, WBURST. Registers: owner (1b), last_grant (1b), beats_left (BURST_W).
- Reset: state=IDLE, last_grant=1, so port 0 is favoured first. While rst_n=0: m_read=m_write=0, r_waitrequest=2'b11, r_readdatavalid=0.
- A port requests when r_read|r_write is set for that port.
- IDLE arbitration is combinational, with zero added latency:
  - Only one port requesting: that port is selected.
  - Both ports requesting, ROUND_ROBIN=1: the port != last_grant is selected.
  - Both ports requesting, ROUND_ROBIN=0: port 0 is selected.
  - The selected port's address, burstcount, read, write, writedata and byteenable drive the m_* outputs.
  - The selected port sees r_waitrequest = m_waitrequest. The other port sees 1.
  - No request: m_read=m_write=0 and both waitrequests are 1.
- Read and write both asserted by one master: the read is serviced and m_write is forced 0 for that cycle.
- burstcount=0 is treated as 1 for counting. The value passes through unchanged to m_burstcount.
- Read accept (IDLE, m_read && !m_waitrequest):
  - owner <= selected port; beats_left <= burstcount; state goes to RBURST.
  - In RBURST, m_read=m_write=0 and both r_waitrequest=1.
  - Each m_readdatavalid raises r_readdatavalid[owner] in the same cycle; r_readdata=m_readdata and r_response=m_response pass through combinationally. beats_left decrements.
  - An error response does not end the burst early.
  - Last beat (beats_left==1 && m_readdatavalid): state goes to IDLE and last_grant <= owner. A new arbitration happens the next cycle, never in the same cycle.
- Write accept (IDLE, first beat m_write && !m_waitrequest):
  - burstcount==1: remain in IDLE and last_grant <= selected port.
  - Otherwise: owner <= selected port, beats_left <= burstcount-1, state goes to WBURST.
  - In WBURST, only the owner's signals are forwarded and the other port's waitrequest is 1. Each accepted beat decrements beats_left.
  - The accept with beats_left==1 moves state to IDLE and sets last_grant <= owner.
  - If the owner drops r_write mid-burst, m_write=0 and the arbiter keeps waiting; ownership is never lost.
- m_readdatavalid outside RBURST is dropped: r_readdatavalid=0.
- A request withdrawn in IDLE before it is accepted simply loses its selection. No state changes.
- Reset mid-burst forces IDLE immediately. In-flight memory beats arriving afterwards are dropped per the rule above.
- r_readdata and r_response are undefined when r_readdatavalid=0.

Test Plan:
- Port 0 reads 0x0 with burstcount 1, memory returns 0xBEAFDEAD after 1 cycle -> r_readdatavalid=2'b01, r_readdata=0xBEAFDEAD, r_response=00; port 1 waitrequest stays 1 throughout.
- Both ports read simultaneously, burstcount 16 each, ROUND_ROBIN=1 -> port 0 gets 16 beats first; port 1 is accepted the cycle after port 0's 16th beat; a third contended pair goes to port 0.
- Port 1 writes a 4-beat burst to 0x100 while port 0 requests a read at beat 2 -> m_address/m_writedata come only from port 1 for all 4 accepts; port 0 is accepted after the 4th accept.
- Read burst of 4 where beat 2 carries m_response=11 -> all 4 beats are forwarded, beat 2 has r_response=11, and the FSM returns to IDLE only after beat 4.
- rst_n low during beat 3 of an 8-beat read -> next cycle state is IDLE, m_read=0, and remaining m_readdatavalid pulses give r_readdatavalid=0.
- ROUND_ROBIN=0 with continuous requests from both ports -> port 0 wins every arbitration and port 1 is never granted.
